// File: rtl/asu_share_ctrl_if.sv
// rtl/asu_share_ctrl_if.sv - requester and response channels of the shared ASU controller
//
// Purpose: bundles both requester valid/ready channels and the tagged
//          response channel of asu_share_ctrl into one interface.
// Signals:
//   req0_* / req1_*  requester operation channels (valid, ready, mode, x, y)
//   rsp_*            response channel (valid, ready, id, data = {carry, out})
// Modports:
//   master  requester/consumer side (drives requests, accepts responses)
//   slave   controller side
interface asu_share_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH:0]   rsp_data;

    modport master (
        output req0_valid, req0_mode, req0_x, req0_y,
        output req1_valid, req1_mode, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_mode, req0_x, req0_y,
        input  req1_valid, req1_mode, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/asu_share_ctrl.sv
// rtl/asu_share_ctrl.sv - round-robin sequencer sharing one add/shift unit between two requesters
//
// Purpose: grants one of two requesters per operation (round-robin under
//          contention), drives the shared combinational ASU from registered
//          operands, captures {carry, out} one cycle later and returns it on a
//          tagged response channel. Keeps a saturating completion count per
//          requester.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             requester/response channels (slave modport)
//   asu_x_o/asu_y_o registered operands to the shared ASU
//   asu_mode_o      registered mode (1 = add, 0 = shift)
//   asu_carry_i     ASU carry result
//   asu_out_i       ASU data result
//   busy_o          high whenever the sequencer is not idle
//   cnt0_o/cnt1_o   saturating completed-response counters
module asu_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    asu_share_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] asu_x_o,
    output logic [WIDTH-1:0] asu_y_o,
    output logic             asu_mode_o,
    input  logic             asu_carry_i,
    input  logic [WIDTH-1:0] asu_out_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] asu_x_q, asu_x_d;
    logic [WIDTH-1:0] asu_y_q, asu_y_d;
    logic             asu_mode_q, asu_mode_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             grant0;
    logic             grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            asu_x_q     <= '0;
            asu_y_q     <= '0;
            asu_mode_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            asu_x_q     <= asu_x_d;
            asu_y_q     <= asu_y_d;
            asu_mode_q  <= asu_mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        asu_x_d     = asu_x_q;
        asu_y_d     = asu_y_q;
        asu_mode_d  = asu_mode_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        grant0      = 1'b0;
        grant1      = 1'b0;

        case (state_q)
            IDLE: begin
                // A lone requester always wins; rr_ptr only breaks ties.
                if (bus.req0_valid && (!bus.req1_valid || !rr_ptr_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end

                if (grant0) begin
                    asu_x_d    = bus.req0_x;
                    asu_y_d    = bus.req0_y;
                    asu_mode_d = bus.req0_mode;
                    id_d       = 1'b0;
                    rr_ptr_d   = 1'b1;
                    state_d    = EXEC;
                end else if (grant1) begin
                    asu_x_d    = bus.req1_x;
                    asu_y_d    = bus.req1_y;
                    asu_mode_d = bus.req1_mode;
                    id_d       = 1'b1;
                    rr_ptr_d   = 1'b0;
                    state_d    = EXEC;
                end
            end

            EXEC: begin
                // ASU is purely combinational on the registered operands, so
                // its result is settled one cycle after the grant.
                rsp_data_d  = {asu_carry_i, asu_out_i};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!rsp_id_q) begin
                        if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
                    end else begin
                        if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Grants only arise in IDLE; masking with rst keeps ready low while the
    // accept edge would be overridden by reset.
    assign bus.req0_ready = grant0 && !rst;
    assign bus.req1_ready = grant1 && !rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;

    assign asu_x_o    = asu_x_q;
    assign asu_y_o    = asu_y_q;
    assign asu_mode_o = asu_mode_q;
    assign busy_o     = (state_q != IDLE);
    assign cnt0_o     = cnt0_q;
    assign cnt1_o     = cnt1_q;
endmodule

// File: tb/tb_asu_share_ctrl.sv
// tb/tb_asu_share_ctrl.sv - directed self-checking bench for asu_share_ctrl
module tb_asu_share_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    asu_share_ctrl_if #(.WIDTH(WIDTH)) bus ();
    asu_share_ctrl_if #(.WIDTH(WIDTH)) sbus ();

    logic [WIDTH-1:0] asu_x, asu_y, asu_out;
    logic             asu_mode, asu_carry, busy;
    logic [15:0]      cnt0, cnt1;
    logic [WIDTH:0]   asu_sum;

    logic [WIDTH-1:0] s_asu_x, s_asu_y, s_asu_out;
    logic             s_asu_mode, s_asu_carry, s_busy;
    logic [1:0]       s_cnt0, s_cnt1;
    logic [WIDTH:0]   s_asu_sum;

    asu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .asu_x_o(asu_x), .asu_y_o(asu_y), .asu_mode_o(asu_mode),
        .asu_carry_i(asu_carry), .asu_out_i(asu_out),
        .busy_o(busy), .cnt0_o(cnt0), .cnt1_o(cnt1)
    );

    asu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(sbus.slave),
        .asu_x_o(s_asu_x), .asu_y_o(s_asu_y), .asu_mode_o(s_asu_mode),
        .asu_carry_i(s_asu_carry), .asu_out_i(s_asu_out),
        .busy_o(s_busy), .cnt0_o(s_cnt0), .cnt1_o(s_cnt1)
    );

    // Shared ASU models: add gives a 9-bit sum, shift is logical left with carry 0.
    assign asu_sum     = {1'b0, asu_x} + {1'b0, asu_y};
    assign asu_out     = asu_mode ? asu_sum[WIDTH-1:0] : (asu_x << asu_y[2:0]);
    assign asu_carry   = asu_mode ? asu_sum[WIDTH] : 1'b0;
    assign s_asu_sum   = {1'b0, s_asu_x} + {1'b0, s_asu_y};
    assign s_asu_out   = s_asu_mode ? s_asu_sum[WIDTH-1:0] : (s_asu_x << s_asu_y[2:0]);
    assign s_asu_carry = s_asu_mode ? s_asu_sum[WIDTH] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_mode = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
        bus.req1_valid = 1'b0; bus.req1_mode = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
        bus.rsp_ready  = 1'b0;
        sbus.req0_valid = 1'b0; sbus.req0_mode = 1'b0; sbus.req0_x = '0; sbus.req0_y = '0;
        sbus.req1_valid = 1'b0; sbus.req1_mode = 1'b0; sbus.req1_x = '0; sbus.req1_y = '0;
        sbus.rsp_ready  = 1'b0;

        // Reset state; a pending request must not see ready during reset.
        step();
        step();
        bus.req0_valid = 1'b1;
        settle();
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_asu_x", 32'(asu_x), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        bus.req0_valid = 1'b0;
        step();
        rst = 1'b0;

        // Add: 0xF0 + 0x20 = 0x110.
        bus.req0_valid = 1'b1; bus.req0_mode = 1'b1; bus.req0_x = 8'hF0; bus.req0_y = 8'h20;
        settle();
        check("add_ready0", 32'(bus.req0_ready), 32'd1);
        check("add_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        check("add_busy", 32'(busy), 32'd1);
        check("add_asu_x", 32'(asu_x), 32'h0F0);
        check("add_asu_y", 32'(asu_y), 32'h020);
        check("add_asu_mode", 32'(asu_mode), 32'd1);
        check("add_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("add_rsp_data", 32'(bus.rsp_data), 32'h110);
        check("add_cnt0_pre", 32'(cnt0), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        check("add_rsp_done", 32'(bus.rsp_valid), 32'd0);
        check("add_cnt0", 32'(cnt0), 32'd1);
        check("add_idle", 32'(busy), 32'd0);

        // Shift: 0x81 << 3 = 0x408 truncated to 0x08, carry 0.
        bus.req1_valid = 1'b1; bus.req1_mode = 1'b0; bus.req1_x = 8'h81; bus.req1_y = 8'h03;
        settle();
        check("shf_ready1", 32'(bus.req1_ready), 32'd1);
        check("shf_ready0", 32'(bus.req0_ready), 32'd0);
        step();
        bus.req1_valid = 1'b0;
        step();
        check("shf_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("shf_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("shf_rsp_data", 32'(bus.rsp_data), 32'h008);
        step();
        check("shf_cnt1", 32'(cnt1), 32'd1);
        check("shf_cnt0", 32'(cnt0), 32'd1);

        // Backpressure: 0xFF + 0x01 = 0x100 held for 5 cycles.
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_mode = 1'b1; bus.req0_x = 8'hFF; bus.req0_y = 8'h01;
        settle();
        check("bp_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req1_valid = 1'b1; bus.req1_mode = 1'b1; bus.req1_x = 8'h11; bus.req1_y = 8'h22;
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'h100);
            check("bp_ready0", 32'(bus.req0_ready), 32'd0);
            check("bp_ready1", 32'(bus.req1_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_cnt0", 32'(cnt0), 32'd1);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        step();
        check("bp_cnt0_after", 32'(cnt0), 32'd2);
        check("bp_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);

        // Reset while in EXEC: req0 granted (rr_ptr moves to 1), then reset.
        bus.req0_valid = 1'b1; bus.req0_x = 8'h01; bus.req0_y = 8'h01;
        step();
        bus.req0_valid = 1'b0;
        check("mid_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cnt0", 32'(cnt0), 32'd0);
        check("mid_cnt1", 32'(cnt1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
            step();
        end

        // Contention: both valid from reset; grants must go 0,1,0,1 every 3 cycles.
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_mode = 1'b1; bus.req0_x = 8'h10; bus.req0_y = 8'h20;
        bus.req1_valid = 1'b1; bus.req1_mode = 1'b0; bus.req1_x = 8'h01; bus.req1_y = 8'h07;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("ct_ready0", 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("ct_ready1", 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            check("ct_exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            step();
            check("ct_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("ct_rsp_id", 32'(bus.rsp_id), 32'(k % 2));
            check("ct_rsp_data", 32'(bus.rsp_data), (k % 2 == 0) ? 32'h030 : 32'h080);
            check("ct_resp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("ct_cnt0", 32'(cnt0), 32'd2);
        check("ct_cnt1", 32'(cnt1), 32'd2);

        // Saturation on the 2-bit counter instance: 1,2,3,3,3.
        sbus.rsp_ready = 1'b1;
        sbus.req0_mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sbus.req0_valid = 1'b1;
            sbus.req0_x = 8'(k + 1);
            sbus.req0_y = 8'h01;
            settle();
            check("sat_ready0", 32'(sbus.req0_ready), 32'd1);
            step();
            sbus.req0_valid = 1'b0;
            step();
            check("sat_rsp_data", 32'(sbus.rsp_data), 32'(k + 2));
            step();
            check("sat_cnt0", 32'(s_cnt0), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        check("sat_cnt1", 32'(s_cnt1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/asu_share_ctrl.md
Name: asu_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational 8-bit add/shift unit (ASU) between two requesters.
- Each requester submits an operation through a valid/ready handshake. The block grants requesters round-robin, drives the shared ASU from registered operands and captures the 9-bit result {carry, out}.
- It returns the result on one response channel tagged with the requester id, and keeps a saturating completed-operation count per requester.

Parameters:
- WIDTH, 8, ASU operand width; fixed by the shared ASU.
- CNT_W, 16, width of each per-requester completion counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_mode  in  1  1 = add, 0 = shift
- req0_x  in  WIDTH  operand x
- req0_y  in  WIDTH  operand y
- req1_valid, req1_ready, req1_mode, req1_x, req1_y  as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH+1  {carry, out} from the ASU
- asu_x  out  WIDTH  registered operand x to the shared ASU
- asu_y  out  WIDTH  registered operand y to the shared ASU
- asu_mode  out  1  registered mode to the shared ASU
- asu_carry  in  1  ASU carry result
- asu_out  in  WIDTH  ASU data result
- busy  out  1  high whenever state != IDLE
- cnt0  out  CNT_W  completed responses for requester 0
- cnt1  out  CNT_W  completed responses for requester 1

Behaviour:
- Shared ASU contract:
  - mode=1: {carry,out} = x + y, 9-bit unsigned sum.
  - mode=0: out = x << y[2:0] (logical, zero fill), carry = 0.
- Reset (rst high at a clk edge):
  - state=IDLE, rr_ptr=0 (requester 0 favored).
  - asu_x/asu_y/asu_mode=0, rsp_valid=0, rsp_id=0, rsp_data=0, cnt0=cnt1=0.
  - req*_ready=0 during reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only one reqN_valid: that requester wins, regardless of rr_ptr.
  - Both valid: the requester equal to rr_ptr wins.
  - Winner's reqN_ready is driven combinationally high the same cycle, gated by state==IDLE and !rst. The loser's ready stays 0.
  - On that edge: latch winner x/y/mode into asu_* registers, latch id, set rr_ptr = ~winner, go to EXEC.
  - No valid: stay in IDLE, hold asu_* values.
- EXEC (exactly 1 cycle):
  - Capture {asu_carry, asu_out} into rsp_data and the latched id into rsp_id.
  - Set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, increment cnt[rsp_id], go to IDLE.
  - Both req*_ready stay 0 while in EXEC and RESP.
- Latency and throughput:
  - Accept at edge T; rsp_valid high after edge T+1.
  - With rsp_ready held high: handshake at T+2 and next accept at T+3.
  - Minimum 3 cycles per operation.
- Counters: saturate at all-ones; the increment is suppressed at max.
- rsp_ready while rsp_valid=0: ignored.
- Requester dropping valid before a grant: permitted; nothing is latched.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is issued, and counters clear.
- rr_ptr changes only on a grant, never on the response handshake.

Test Plan:
- Add: after reset, req0 valid with mode=1, x=8'hF0, y=8'h20 -> req0_ready=1 in that cycle; after 2 edges rsp_valid=1, rsp_id=0, rsp_data=9'h110; cnt0=1 after handshake.
- Shift: req1 valid with mode=0, x=8'h81, y=8'h03 -> rsp_data=9'h008, rsp_id=1.
- Contention: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1, spaced 3 cycles apart; cnt0=cnt1=2 after 4 responses.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data are stable, both ready=0, busy=1, counters unchanged until rsp_ready=1.
- Reset mid-op: rst asserted for 1 cycle while in EXEC -> no rsp_valid afterwards, state=IDLE, cnt0=cnt1=0, rr_ptr=0.
- Saturation: with CNT_W=2, 5 requester-0 ops -> cnt0 reads 1,2,3,3,3.
